// File: rtl/rob_pkg.sv
// Shared types and constants for the parametrised reorder buffer.
package rob_pkg;

  localparam int XCPT_TYPE_W = 3;
  localparam int ROB_DATA_W  = 32;
  localparam int ROB_REG_W   = 5;

  typedef enum logic [XCPT_TYPE_W-1:0] {
    XCPT_NONE        = 3'd0,
    XCPT_ILLEGAL     = 3'd1,
    XCPT_LOAD_FAULT  = 3'd2,
    XCPT_STORE_FAULT = 3'd3,
    XCPT_MISALIGN    = 3'd4
  } xcpt_cause_e;

  // Entry layout at the default widths; the top builds the same layout from its own parameters.
  typedef struct packed {
    logic                   rf_wen;
    logic [ROB_REG_W-1:0]   dest;
    logic [ROB_DATA_W-1:0]  data;
    logic                   xcpt_valid;
    logic [XCPT_TYPE_W-1:0] xcpt_type;
    logic [ROB_DATA_W-1:0]  xcpt_pc;
    logic [ROB_DATA_W-1:0]  xcpt_addr;
  } rob_entry_t;

endpackage

// File: rtl/rob_src_lookup.sv
// One operand lookup port: completed ROB entry first, then same-cycle writeback bypass.
module rob_src_lookup #(
  parameter int ROB_ENTRIES = 8,
  parameter int WB_PORTS    = 3,
  parameter int DATA_W      = 32,
  parameter int ID_W        = $clog2(ROB_ENTRIES)
) (
  input  logic [ID_W-1:0]                     src_id,
  input  logic [ROB_ENTRIES-1:0]              fwd_ok,
  input  logic [ROB_ENTRIES-1:0][DATA_W-1:0]  stored_data,
  input  logic [WB_PORTS-1:0]                 wb_valid,
  input  logic [WB_PORTS*ID_W-1:0]            wb_id,
  input  logic [WB_PORTS-1:0]                 wb_rf_wen,
  input  logic [WB_PORTS-1:0]                 wb_xcpt_valid,
  input  logic [WB_PORTS*DATA_W-1:0]          wb_data,
  output logic                                hit,
  output logic [DATA_W-1:0]                   data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (fwd_ok[src_id]) begin
      hit  = 1'b1;
      data = stored_data[src_id];
    end else begin
      // Descending scan so the lowest matching port is the last assignment.
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
        if (wb_valid[p] && wb_rf_wen[p] && !wb_xcpt_valid[p] &&
            wb_id[p*ID_W +: ID_W] == src_id) begin
          hit  = 1'b1;
          data = wb_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/reorder_buffer_param.sv
// In-order-commit reorder buffer with out-of-order multi-port writeback and operand forwarding.
module reorder_buffer_param
  import rob_pkg::*;
#(
  parameter int ROB_ENTRIES = 8,
  parameter int WB_PORTS    = 3,
  parameter int SRC_PORTS   = 4,
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  localparam int ID_W       = $clog2(ROB_ENTRIES)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             alloc_valid,
  output logic                             alloc_ready,
  output logic [ID_W-1:0]                  alloc_id,
  input  logic [WB_PORTS-1:0]              wb_valid,
  input  logic [WB_PORTS*ID_W-1:0]         wb_id,
  input  logic [WB_PORTS-1:0]              wb_rf_wen,
  input  logic [WB_PORTS*REG_W-1:0]        wb_dest,
  input  logic [WB_PORTS*DATA_W-1:0]       wb_data,
  input  logic [WB_PORTS-1:0]              wb_xcpt_valid,
  input  logic [WB_PORTS*XCPT_TYPE_W-1:0]  wb_xcpt_type,
  input  logic [WB_PORTS*DATA_W-1:0]       wb_xcpt_pc,
  input  logic [WB_PORTS*DATA_W-1:0]       wb_xcpt_addr,
  output logic                             req_to_RF_writeEn,
  output logic [REG_W-1:0]                 req_to_RF_dest,
  output logic [DATA_W-1:0]                req_to_RF_data,
  output logic [ID_W-1:0]                  req_to_RF_instr_id,
  output logic                             xcpt_valid,
  output logic [XCPT_TYPE_W-1:0]           xcpt_type,
  output logic [DATA_W-1:0]                xcpt_pc,
  output logic [DATA_W-1:0]                xcpt_addr,
  output logic [ID_W-1:0]                  rob_oldest,
  output logic [ID_W:0]                    rob_count,
  input  logic [SRC_PORTS*ID_W-1:0]        src_id,
  output logic [SRC_PORTS-1:0]             src_hit,
  output logic [SRC_PORTS*DATA_W-1:0]      src_data
);

  typedef struct packed {
    logic                   rf_wen;
    logic [REG_W-1:0]       dest;
    logic [DATA_W-1:0]      data;
    logic                   xcpt_valid;
    logic [XCPT_TYPE_W-1:0] xcpt_type;
    logic [DATA_W-1:0]      xcpt_pc;
    logic [DATA_W-1:0]      xcpt_addr;
  } entry_t;

  localparam logic [ID_W:0] COUNT_FULL = (ID_W+1)'(ROB_ENTRIES);

  logic [ROB_ENTRIES-1:0] alloc_ff, done_ff;
  entry_t                 payload_ff [ROB_ENTRIES];
  logic [ID_W-1:0]        head_ff, tail_ff;
  logic [ID_W:0]          count_ff;

  logic [ID_W-1:0] wb_id_a    [WB_PORTS];
  entry_t          wb_entry   [WB_PORTS];
  logic [WB_PORTS-1:0] wb_en;
  entry_t          tail_entry;
  logic            commit_vis, commit_fire, xcpt_commit, clear_all, alloc_fire;

  for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb_unpack
    assign wb_id_a[p]             = wb_id[p*ID_W +: ID_W];
    assign wb_entry[p].rf_wen     = wb_rf_wen[p];
    assign wb_entry[p].dest       = wb_dest[p*REG_W +: REG_W];
    assign wb_entry[p].data       = wb_data[p*DATA_W +: DATA_W];
    assign wb_entry[p].xcpt_valid = wb_xcpt_valid[p];
    assign wb_entry[p].xcpt_type  = wb_xcpt_type[p*XCPT_TYPE_W +: XCPT_TYPE_W];
    assign wb_entry[p].xcpt_pc    = wb_xcpt_pc[p*DATA_W +: DATA_W];
    assign wb_entry[p].xcpt_addr  = wb_xcpt_addr[p*DATA_W +: DATA_W];
    assign wb_en[p] = wb_valid[p] & alloc_ff[wb_id_a[p]] & ~clear_all;
  end

  assign tail_entry  = payload_ff[tail_ff];
  assign commit_vis  = ~flush & alloc_ff[tail_ff] & done_ff[tail_ff];
  assign xcpt_commit = commit_vis & tail_entry.xcpt_valid;
  assign commit_fire = commit_vis & ~tail_entry.xcpt_valid;
  // An exception commit drains the whole window at the next edge, exactly like flush.
  assign clear_all   = flush | xcpt_commit;
  assign alloc_ready = (count_ff != COUNT_FULL);
  assign alloc_fire  = alloc_valid & alloc_ready & ~clear_all;

  assign alloc_id           = head_ff;
  assign rob_oldest         = tail_ff;
  assign rob_count          = count_ff;
  assign req_to_RF_writeEn  = commit_fire & tail_entry.rf_wen;
  assign req_to_RF_dest     = commit_fire ? tail_entry.dest : '0;
  assign req_to_RF_data     = commit_fire ? tail_entry.data : '0;
  assign req_to_RF_instr_id = commit_vis ? tail_ff : '0;
  assign xcpt_valid         = xcpt_commit;
  assign xcpt_type          = xcpt_commit ? tail_entry.xcpt_type : '0;
  assign xcpt_pc            = xcpt_commit ? tail_entry.xcpt_pc : '0;
  assign xcpt_addr          = xcpt_commit ? tail_entry.xcpt_addr : '0;

  always_ff @(posedge clock) begin
    if (!reset || clear_all) begin
      alloc_ff <= '0;
      done_ff  <= '0;
      head_ff  <= '0;
      tail_ff  <= '0;
      count_ff <= '0;
    end else begin
      // Descending so the lowest port's write is the one that lands on a shared ID.
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
        if (wb_en[p]) begin
          done_ff[wb_id_a[p]]    <= 1'b1;
          payload_ff[wb_id_a[p]] <= wb_entry[p];
        end
      end
      if (commit_fire) begin
        alloc_ff[tail_ff] <= 1'b0;
        done_ff[tail_ff]  <= 1'b0;
        tail_ff           <= tail_ff + ID_W'(1);
      end
      if (alloc_fire) begin
        alloc_ff[head_ff] <= 1'b1;
        done_ff[head_ff]  <= 1'b0;
        head_ff           <= head_ff + ID_W'(1);
      end
      count_ff <= count_ff + {{ID_W{1'b0}}, alloc_fire} - {{ID_W{1'b0}}, commit_fire};
    end
  end

  always_ff @(posedge clock) begin
    if (reset && !clear_all) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p]) begin
          assert (alloc_ff[wb_id_a[p]])
            else $error("rob: writeback on port %0d to unallocated id %0d", p, wb_id_a[p]);
          for (int q = 0; q < p; q++) begin
            assert (!(wb_valid[q] && wb_id_a[q] == wb_id_a[p]))
              else $error("rob: writeback ports %0d and %0d collide on id %0d", q, p, wb_id_a[p]);
          end
        end
      end
    end
  end

  logic [ROB_ENTRIES-1:0]             fwd_ok;
  logic [ROB_ENTRIES-1:0][DATA_W-1:0] stored_data;

  always_comb begin
    fwd_ok      = '0;
    stored_data = '0;
    for (int e = 0; e < ROB_ENTRIES; e++) begin
      fwd_ok[e]      = alloc_ff[e] & done_ff[e] & payload_ff[e].rf_wen & ~payload_ff[e].xcpt_valid;
      stored_data[e] = payload_ff[e].data;
    end
  end

  for (genvar s = 0; s < SRC_PORTS; s++) begin : g_src
    rob_src_lookup #(
      .ROB_ENTRIES(ROB_ENTRIES),
      .WB_PORTS   (WB_PORTS),
      .DATA_W     (DATA_W),
      .ID_W       (ID_W)
    ) u_lookup (
      .src_id       (src_id[s*ID_W +: ID_W]),
      .fwd_ok       (fwd_ok),
      .stored_data  (stored_data),
      .wb_valid     (wb_valid),
      .wb_id        (wb_id),
      .wb_rf_wen    (wb_rf_wen),
      .wb_xcpt_valid(wb_xcpt_valid),
      .wb_data      (wb_data),
      .hit          (src_hit[s]),
      .data         (src_data[s*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reorder_buffer_param.sv
// Directed bench for reorder_buffer_param at 8 entries, 3 writeback ports, 4 lookup ports.
module tb_reorder_buffer_param;

  localparam int N  = 8;
  localparam int WP = 3;
  localparam int SP = 4;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int IW = 3;
  localparam int XW = 3;

  logic clock = 1'b0;
  logic reset, flush, alloc_valid;
  logic alloc_ready;
  logic [IW-1:0] alloc_id;
  logic [WP-1:0] wb_valid, wb_rf_wen, wb_xcpt_valid;
  logic [WP*IW-1:0] wb_id;
  logic [WP*RW-1:0] wb_dest;
  logic [WP*DW-1:0] wb_data, wb_xcpt_pc, wb_xcpt_addr;
  logic [WP*XW-1:0] wb_xcpt_type;
  logic req_we;
  logic [RW-1:0] req_dest;
  logic [DW-1:0] req_data;
  logic [IW-1:0] req_id;
  logic x_valid;
  logic [XW-1:0] x_type;
  logic [DW-1:0] x_pc, x_addr;
  logic [IW-1:0] rob_oldest;
  logic [IW:0] rob_count;
  logic [SP*IW-1:0] src_id;
  logic [SP-1:0] src_hit;
  logic [SP*DW-1:0] src_data;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  reorder_buffer_param #(
    .ROB_ENTRIES(N), .WB_PORTS(WP), .SRC_PORTS(SP), .DATA_W(DW), .REG_W(RW)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_rf_wen(wb_rf_wen), .wb_dest(wb_dest),
    .wb_data(wb_data), .wb_xcpt_valid(wb_xcpt_valid), .wb_xcpt_type(wb_xcpt_type),
    .wb_xcpt_pc(wb_xcpt_pc), .wb_xcpt_addr(wb_xcpt_addr),
    .req_to_RF_writeEn(req_we), .req_to_RF_dest(req_dest), .req_to_RF_data(req_data),
    .req_to_RF_instr_id(req_id),
    .xcpt_valid(x_valid), .xcpt_type(x_type), .xcpt_pc(x_pc), .xcpt_addr(x_addr),
    .rob_oldest(rob_oldest), .rob_count(rob_count),
    .src_id(src_id), .src_hit(src_hit), .src_data(src_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_wb();
    wb_valid = '0; wb_id = '0; wb_rf_wen = '0; wb_dest = '0; wb_data = '0;
    wb_xcpt_valid = '0; wb_xcpt_type = '0; wb_xcpt_pc = '0; wb_xcpt_addr = '0;
  endtask

  task automatic set_wb(input int p, input logic [IW-1:0] id, input logic rf_wen,
                        input logic [RW-1:0] dest, input logic [DW-1:0] data,
                        input logic xv, input logic [XW-1:0] xt,
                        input logic [DW-1:0] pc, input logic [DW-1:0] addr);
    wb_valid[p] = 1'b1;
    wb_id[p*IW +: IW] = id;
    wb_rf_wen[p] = rf_wen;
    wb_dest[p*RW +: RW] = dest;
    wb_data[p*DW +: DW] = data;
    wb_xcpt_valid[p] = xv;
    wb_xcpt_type[p*XW +: XW] = xt;
    wb_xcpt_pc[p*DW +: DW] = pc;
    wb_xcpt_addr[p*DW +: DW] = addr;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; alloc_valid = 1'b0; src_id = '0;
    clear_wb();

    // reset low for two edges, then idle state
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_alloc_id", 64'(alloc_id), 64'd0);
    chk("rst_count", 64'(rob_count), 64'd0);
    chk("rst_we", 64'(req_we), 64'd0);
    chk("rst_xcpt", 64'(x_valid), 64'd0);
    chk("rst_src_hit", 64'(src_hit), 64'd0);

    // fill: ids 0..7 in order, then full
    for (int i = 0; i < N; i++) begin
      alloc_valid = 1'b1;
      #1;
      chk("fill_id", 64'(alloc_id), 64'(i));
      chk("fill_ready", 64'(alloc_ready), 64'd1);
      tick();
    end
    alloc_valid = 1'b0;
    #1;
    chk("full_ready", 64'(alloc_ready), 64'd0);
    chk("full_count", 64'(rob_count), 64'd8);

    // out-of-order writeback, in-order commit
    set_wb(0, 3'd2, 1'b1, 5'd2, 32'h20, 1'b0, 3'd0, 32'h0, 32'h0);
    #1; chk("ooo_we_t", 64'(req_we), 64'd0);
    tick(); clear_wb();
    set_wb(1, 3'd1, 1'b1, 5'd1, 32'h10, 1'b0, 3'd0, 32'h0, 32'h0);
    #1; chk("ooo_we_t1", 64'(req_we), 64'd0);
    tick(); clear_wb();
    set_wb(2, 3'd0, 1'b1, 5'd9, 32'h00, 1'b0, 3'd0, 32'h0, 32'h0);
    #1; chk("ooo_we_t2_nobypass", 64'(req_we), 64'd0);
    tick(); clear_wb();
    #1;
    chk("c0_we", 64'(req_we), 64'd1);
    chk("c0_id", 64'(req_id), 64'd0);
    chk("c0_dest", 64'(req_dest), 64'd9);
    chk("c0_count", 64'(rob_count), 64'd8);
    tick();
    chk("c1_we", 64'(req_we), 64'd1);
    chk("c1_id", 64'(req_id), 64'd1);
    chk("c1_data", 64'(req_data), 64'h10);
    chk("c1_count", 64'(rob_count), 64'd7);
    tick();
    chk("c2_id", 64'(req_id), 64'd2);
    chk("c2_data", 64'(req_data), 64'h20);
    chk("c2_count", 64'(rob_count), 64'd6);
    tick();
    chk("c3_idle_we", 64'(req_we), 64'd0);
    chk("c3_oldest", 64'(rob_oldest), 64'd3);
    chk("c3_count", 64'(rob_count), 64'd5);

    // exception on id3 with id4 already done
    set_wb(0, 3'd4, 1'b1, 5'd4, 32'h44, 1'b0, 3'd0, 32'h0, 32'h0);
    set_wb(1, 3'd3, 1'b1, 5'd3, 32'h33, 1'b1, 3'd2, 32'h100, 32'hDEAD);
    tick(); clear_wb();
    alloc_valid = 1'b1;
    #1;
    chk("x_valid", 64'(x_valid), 64'd1);
    chk("x_type", 64'(x_type), 64'd2);
    chk("x_pc", 64'(x_pc), 64'h100);
    chk("x_addr", 64'(x_addr), 64'hDEAD);
    chk("x_we", 64'(req_we), 64'd0);
    tick();
    alloc_valid = 1'b0;
    #1;
    chk("x_after_count", 64'(rob_count), 64'd0);
    chk("x_after_alloc_id", 64'(alloc_id), 64'd0);
    chk("x_after_xvalid", 64'(x_valid), 64'd0);
    chk("x_after_we", 64'(req_we), 64'd0);
    tick();
    chk("x_id4_dropped", 64'(req_we), 64'd0);

    // wrap: fill, then commit ids 0..6 while reallocating ids 0..6
    for (int i = 0; i < N; i++) begin
      alloc_valid = 1'b1;
      #1;
      chk("wrap_fill_id", 64'(alloc_id), 64'(i));
      tick();
    end
    alloc_valid = 1'b0;
    for (int c = 0; c < 9; c++) begin
      clear_wb();
      if (c == 0) begin
        for (int p = 0; p < 3; p++)
          set_wb(p, IW'(p), 1'b1, RW'(p), DW'(p * 32'h11), 1'b0, 3'd0, 32'h0, 32'h0);
      end else if (c == 1) begin
        for (int p = 0; p < 3; p++)
          set_wb(p, IW'(p + 3), 1'b1, RW'(p + 3), DW'((p + 3) * 32'h11), 1'b0, 3'd0, 32'h0, 32'h0);
      end else if (c == 2) begin
        set_wb(0, 3'd6, 1'b1, 5'd6, 32'h66, 1'b0, 3'd0, 32'h0, 32'h0);
      end
      alloc_valid = (c >= 1);
      #1;
      chk("wrap_we", 64'(req_we), (c >= 1 && c <= 7) ? 64'd1 : 64'd0);
      if (c >= 1 && c <= 7) begin
        chk("wrap_commit_id", 64'(req_id), 64'(c - 1));
        chk("wrap_commit_data", 64'(req_data), 64'((c - 1) * 32'h11));
      end
      chk("wrap_ready", 64'(alloc_ready), (c >= 2) ? 64'd1 : 64'd0);
      if (c >= 2) chk("wrap_alloc_id", 64'(alloc_id), 64'(c - 2));
      chk("wrap_count", 64'(rob_count), (c <= 1) ? 64'd8 : 64'd7);
      tick();
    end
    clear_wb();
    alloc_valid = 1'b0;
    #1;
    chk("wrap_end_count", 64'(rob_count), 64'd8);
    chk("wrap_end_ready", 64'(alloc_ready), 64'd0);
    chk("wrap_end_oldest", 64'(rob_oldest), 64'd7);

    // lookup: same-cycle bypass, then from storage; xcpt result never forwards
    src_id[0*IW +: IW] = 3'd5;
    src_id[1*IW +: IW] = 3'd6;
    set_wb(1, 3'd5, 1'b1, 5'd5, 32'hABCD, 1'b0, 3'd0, 32'h0, 32'h0);
    set_wb(2, 3'd6, 1'b1, 5'd6, 32'h6666, 1'b1, 3'd1, 32'h0, 32'h0);
    #1;
    chk("src_byp_hit", 64'(src_hit[0]), 64'd1);
    chk("src_byp_data", 64'(src_data[0 +: DW]), 64'hABCD);
    chk("src_xcpt_hit", 64'(src_hit[1]), 64'd0);
    chk("src_xcpt_data", 64'(src_data[DW +: DW]), 64'd0);
    tick(); clear_wb();
    #1;
    chk("src_st_hit", 64'(src_hit[0]), 64'd1);
    chk("src_st_data", 64'(src_data[0 +: DW]), 64'hABCD);
    chk("src_st_xcpt_hit", 64'(src_hit[1]), 64'd0);
    src_id = '0;

    // flush with a commit pending and writebacks in flight
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("fl0_count", 64'(rob_count), 64'd0);
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1;
      tick();
    end
    alloc_valid = 1'b0;
    set_wb(0, 3'd0, 1'b1, 5'd7, 32'h77, 1'b0, 3'd0, 32'h0, 32'h0);
    tick(); clear_wb();
    #1;
    chk("fl_pre_we", 64'(req_we), 64'd1);
    chk("fl_pre_count", 64'(rob_count), 64'd5);
    flush = 1'b1;
    alloc_valid = 1'b1;
    for (int p = 0; p < 3; p++)
      set_wb(p, IW'(p + 1), 1'b1, RW'(p), 32'h55, 1'b0, 3'd0, 32'h0, 32'h0);
    #1;
    chk("fl_we", 64'(req_we), 64'd0);
    chk("fl_data", 64'(req_data), 64'd0);
    chk("fl_xcpt", 64'(x_valid), 64'd0);
    tick();
    flush = 1'b0; alloc_valid = 1'b0; clear_wb();
    #1;
    chk("fl_count", 64'(rob_count), 64'd0);
    chk("fl_alloc_id", 64'(alloc_id), 64'd0);
    chk("fl_ready", 64'(alloc_ready), 64'd1);
    chk("fl_we_after", 64'(req_we), 64'd0);

    // reset in mid-operation
    alloc_valid = 1'b1; tick(); tick();
    alloc_valid = 1'b0;
    set_wb(0, 3'd0, 1'b1, 5'd1, 32'h1234, 1'b0, 3'd0, 32'h0, 32'h0);
    tick(); clear_wb();
    #1;
    chk("rm_pre_we", 64'(req_we), 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("rm_count", 64'(rob_count), 64'd0);
    chk("rm_we", 64'(req_we), 64'd0);
    chk("rm_alloc_id", 64'(alloc_id), 64'd0);
    chk("rm_oldest", 64'(rob_oldest), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
